// File: rtl/gal_olmc_bank.sv
// Bank of 22V10-style output logic macrocells: registered/combinational data path,
// polarity select, tristate enable, and AND-array feedback with a shared reset synchroniser.
module gal_olmc_bank #(
   parameter int             N           = 8,
   parameter logic [N-1:0]   REGISTERED  = {N{1'b0}},
   parameter logic [N-1:0]   ACTIVE_HIGH = {N{1'b1}}
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] sop_y,
   input  logic [N-1:0] oe_y,
   input  logic         ar,
   input  logic         sp,
   input  logic [N-1:0] pin_in,
   output logic [N-1:0] pin_out,
   output logic [N-1:0] pin_oe,
   output logic [N-1:0] fb
);

   logic         s1;
   logic         s2;
   logic         rst_sync;
   logic         clr_b;
   logic [N-1:0] q;
   logic [N-1:0] d;
   logic [N-1:0] pin_fb;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= 1'b1;
         s2 <= s1;
      end
   end

   assign rst_sync = s2;

   // Holding the registers in clear until rst_sync is high makes the edge that
   // sets s2 a non-capture edge, so the first capture is the third edge.
   assign clr_b = rst_n & rst_sync & ~ar;

   for (genvar i = 0; i < N; i++) begin : g_cell
      if (REGISTERED[i]) begin : g_reg
         logic q_cell;
         always_ff @(posedge clk or negedge clr_b) begin
            if (!clr_b) begin
               q_cell <= 1'b0;
            end else begin
               q_cell <= sp ? 1'b1 : sop_y[i];
            end
         end
         assign q[i] = q_cell;
      end else begin : g_comb
         assign q[i] = 1'b0;
      end
   end

   assign d       = (REGISTERED & q) | (~REGISTERED & sop_y);
   assign pin_out = d ^ ~ACTIVE_HIGH;
   assign pin_oe  = oe_y;

   // Combinational cells read their pad back, so a disabled cell acts as an input.
   assign pin_fb  = (oe_y & pin_out) | (~oe_y & pin_in);
   assign fb      = (REGISTERED & q) | (~REGISTERED & pin_fb);

endmodule

// File: tb/tb_gal_olmc_bank.sv
// Bench for gal_olmc_bank: three parameterisations share one stimulus stream and
// are checked every cycle against a bit-level model of the macrocell rules.
module tb_gal_olmc_bank;

   localparam logic [7:0] REG_A = 8'hFF, AH_A = 8'h0F;
   localparam logic [7:0] REG_B = 8'h00, AH_B = 8'hFF;
   localparam logic [7:0] REG_C = 8'hA5, AH_C = 8'h3C;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] sop_y, oe_y, pin_in;
   logic       ar, sp;
   logic [7:0] po_a, oe_a, fb_a;
   logic [7:0] po_b, oe_b, fb_b;
   logic [7:0] po_c, oe_c, fb_c;

   int tests = 0;
   int fails = 0;

   // model state: edges seen since reset release, and the value every registered cell holds
   int         rel_edges;
   logic [7:0] qm;

   always #5 clk = ~clk;

   gal_olmc_bank #(.N(8), .REGISTERED(REG_A), .ACTIVE_HIGH(AH_A)) u_reg (
      .clk(clk), .rst_n(rst_n), .sop_y(sop_y), .oe_y(oe_y), .ar(ar), .sp(sp),
      .pin_in(pin_in), .pin_out(po_a), .pin_oe(oe_a), .fb(fb_a));

   gal_olmc_bank #(.N(8), .REGISTERED(REG_B), .ACTIVE_HIGH(AH_B)) u_comb (
      .clk(clk), .rst_n(rst_n), .sop_y(sop_y), .oe_y(oe_y), .ar(ar), .sp(sp),
      .pin_in(pin_in), .pin_out(po_b), .pin_oe(oe_b), .fb(fb_b));

   gal_olmc_bank #(.N(8), .REGISTERED(REG_C), .ACTIVE_HIGH(AH_C)) u_mix (
      .clk(clk), .rst_n(rst_n), .sop_y(sop_y), .oe_y(oe_y), .ar(ar), .sp(sp),
      .pin_in(pin_in), .pin_out(po_c), .pin_oe(oe_c), .fb(fb_c));

   task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic model_out(input logic [7:0] reg_m, input logic [7:0] ah,
                            output logic [7:0] po, output logic [7:0] fbv);
      for (int b = 0; b < 8; b++) begin
         logic dv;
         dv     = reg_m[b] ? qm[b] : sop_y[b];
         po[b]  = ah[b] ? dv : ~dv;
         fbv[b] = reg_m[b] ? qm[b] : (oe_y[b] ? po[b] : pin_in[b]);
      end
   endtask

   task automatic compare_all();
      logic [7:0] po, fbv;
      model_out(REG_A, AH_A, po, fbv);
      chk("reg pin_out", po_a, po);  chk("reg fb", fb_a, fbv);  chk("reg pin_oe", oe_a, oe_y);
      model_out(REG_B, AH_B, po, fbv);
      chk("comb pin_out", po_b, po); chk("comb fb", fb_b, fbv); chk("comb pin_oe", oe_b, oe_y);
      model_out(REG_C, AH_C, po, fbv);
      chk("mix pin_out", po_c, po);  chk("mix fb", fb_c, fbv);  chk("mix pin_oe", oe_c, oe_y);
   endtask

   task automatic drive_rst(input logic v);
      rst_n = v;
      if (!v) begin
         rel_edges = 0;
         qm        = 8'h00;
      end
   endtask

   task automatic drive_ar(input logic v);
      ar = v;
      if (v) qm = 8'h00;
   endtask

   // One clock: model capture at the edge, optional new random inputs, compare at the falling edge.
   task automatic tick(input bit rnd);
      @(posedge clk);
      if (rst_n) begin
         if (rel_edges >= 2 && !ar) qm = sp ? 8'hFF : sop_y;
         if (rel_edges < 2) rel_edges++;
      end
      #2;
      if (rnd) begin
         sop_y  = 8'($urandom);
         oe_y   = 8'($urandom);
         pin_in = 8'($urandom);
         sp     = ($urandom_range(0, 7) == 0);
         drive_ar($urandom_range(0, 15) == 0);
         drive_rst($urandom_range(0, 39) != 0);
      end
      @(negedge clk);
      compare_all();
   endtask

   initial begin
      rel_edges = 0;
      qm        = 8'h00;
      rst_n     = 1'b0;
      ar        = 1'b0;
      sp        = 1'b0;
      sop_y     = 8'hA5;
      oe_y      = 8'hFF;
      pin_in    = 8'h00;

      // reset hold and three-edge release
      #12;
      chk("t1 reset pin_out", po_a, 8'hF0);
      chk("t1 reset fb", fb_a, 8'h00);
      compare_all();
      drive_rst(1'b1);
      tick(0); chk("t1 edge1 pin_out", po_a, 8'hF0);
      tick(0); chk("t1 edge2 pin_out", po_a, 8'hF0);
      tick(0); chk("t1 edge3 pin_out", po_a, 8'h55);
      chk("t1 edge3 fb", fb_a, 8'hA5);

      // synchronous preset, asynchronous reset, and ar beating sp
      sp = 1'b1; sop_y = 8'h00;
      tick(0); chk("t2 preset pin_out", po_a, 8'h0F);
      sp = 1'b0;
      #1 drive_ar(1'b1);
      #1 chk("t2 ar immediate", po_a, 8'hF0);
      compare_all();
      sp = 1'b1;
      tick(0); chk("t2 ar over sp", po_a, 8'hF0);
      drive_ar(1'b0); sp = 1'b0;

      // combinational cells follow sop_y with no clock and ignore rst_n
      sop_y = 8'h3C; oe_y = 8'hFF;
      #1 chk("t3 comb pin_out 3C", po_b, 8'h3C); chk("t3 comb fb 3C", fb_b, 8'h3C);
      sop_y = 8'hC3;
      #1 chk("t3 comb pin_out C3", po_b, 8'hC3); chk("t3 comb fb C3", fb_b, 8'hC3);
      drive_rst(1'b0);
      #1 chk("t3 rst comb pin_out", po_b, 8'hC3); chk("t3 rst reg pin_out", po_a, 8'hF0);
      drive_rst(1'b1);
      tick(0);

      // pin feedback through disabled pads
      sop_y = 8'h00; oe_y = 8'h0F; pin_in = 8'hB0;
      #1 chk("t4 fb pin_in", fb_b, 8'hB0); chk("t4 pin_oe", oe_b, 8'h0F);
      oe_y = 8'hFF;
      #1 chk("t4 fb driven", fb_b, 8'h00);
      tick(0); tick(0);

      // buried register still feeds back
      oe_y = 8'h00; sop_y = 8'h01;
      tick(0);
      chk("t5 buried fb0", {7'd0, fb_c[0]}, 8'h01);
      chk("t5 buried oe0", {7'd0, oe_c[0]}, 8'h00);

      // short mid-stream reset pulse, then the release sequence again
      sop_y = 8'hFF;
      #1 drive_rst(1'b0);
      #1 chk("t6 rst pulse pin_out", po_a, 8'hF0);
      #2 drive_rst(1'b1);
      tick(0); chk("t6 edge1 pin_out", po_a, 8'hF0);
      tick(0); chk("t6 edge2 pin_out", po_a, 8'hF0);
      tick(0); chk("t6 edge3 pin_out", po_a, 8'h0F);

      for (int n = 0; n < 400; n++) tick(1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
